pool_channel_scheduler: RTL
===========================

Name: pool_channel_scheduler

Overview:
Sequences the 7x7 pooling/convolution window engine over a multi-channel feature map, one channel at a time. Reads each channel's pixels from the input feature memory and streams them into the engine. After each channel it appends zero flush pixels to drain the line buffer, then clears the engine between channels. Collects the engine's valid outputs into the output feature memory at channel-packed addresses and reports done and error status to the layer controller.

Parameters:
IMG_Width, 7, feature-map width in pixels
IMG_Height, 7, feature-map height in pixels
NUM_CH, 4, channels processed per start
Datawidth, 16, pixel width
FLUSH_LEN, IMG_Width*3+4, zero pixels fed after each channel to drain the line buffer
OUT_PER_CH, IMG_Width*IMG_Height, engine outputs expected per channel
CLR_CYCLES, 2, engine-clear pulse length between channels
TIMEOUT, 256, maximum DRAIN cycles before the error flag is set
AW, 16, memory address width

Ports:
CLK  in  1  clock
CLR  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a layer; ignored unless idle
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the last channel completes
err_timeout  out  1  sticky; a channel's drain timed out
err_overflow  out  1  sticky; engine produced more than OUT_PER_CH outputs in a channel
rd_en  out  1  input memory read strobe
rd_addr  out  AW  input memory address
rd_data  in  Datawidth  input memory data, valid exactly 1 cycle after rd_en
eng_clr  out  1  engine clear (drives engine CLR)
eng_valid_in  out  1  engine Valid_IN
eng_in  out  Datawidth  engine pixel input
eng_valid_out  in  1  engine Valid_OUT
eng_out  in  Datawidth  engine result
wr_en  out  1  output memory write strobe
wr_addr  out  AW  output memory address
wr_data  out  Datawidth  output memory data

Behaviour:
- Reset (CLR=1): state=IDLE; all outputs 0, including sticky errors; all counters 0. CLR mid-operation aborts immediately; no done pulse.
- While CLR is asserted, eng_clr=1 (engine is reset with the block).
- States: IDLE, CLEAR, FEED, FLUSH, DRAIN, NEXT, DONE.
- IDLE: on start, clear ch, err_timeout and err_overflow, and set busy; go to CLEAR.
- CLEAR: eng_clr=1 for CLR_CYCLES cycles; pix_cnt=0 and out_cnt=0; go to FEED.
- FEED:
  - rd_en=1 every cycle, rd_addr = ch*OUT_PER_CH + pix_cnt, for pix_cnt 0..W*H-1.
  - eng_valid_in and eng_in are rd_en and rd_data registered by one cycle. First eng_valid_in occurs 1 cycle after first rd_en.
  - After issuing the last address, go to FLUSH.
- FLUSH:
  - eng_valid_in=1 and eng_in=0 for exactly FLUSH_LEN cycles.
  - The last FEED pixel and the first flush zero are on consecutive cycles; there is no bubble.
  - Go to DRAIN.
- DRAIN:
  - eng_valid_in=0.
  - Wait until out_cnt==OUT_PER_CH, then go to NEXT.
  - If TIMEOUT cycles elapse first, set err_timeout and go to NEXT.
- Output capture is active in FEED, FLUSH and DRAIN:
  - Each eng_valid_out with out_cnt<OUT_PER_CH registers, 1 cycle later, wr_en=1, wr_addr = ch*OUT_PER_CH + out_cnt, wr_data=eng_out; out_cnt then increments.
  - eng_valid_out with out_cnt==OUT_PER_CH is dropped and sets err_overflow.
  - eng_valid_out in IDLE or CLEAR is ignored.
- NEXT: if ch==NUM_CH-1, go to DONE; else ch++ and go to CLEAR.
- DONE: done=1 for one cycle, busy=0; go to IDLE. A start in the DONE cycle is ignored.
- Address arithmetic is AW bits wide. NUM_CH*OUT_PER_CH must be <= 2^AW; this is checked by an elaboration-time assertion.
- The pipeline carries no backpressure; the memories must accept one access per cycle.

Decomposition:
- Shared package pool_sched_pkg holds:
  - state enum (IDLE..DONE);
  - localparams PIX_PER_CH and address-width helpers;
  - the clog2-based counter widths.
- One sub-module is natural: pool_out_collector. It contains out_cnt, the overflow check, wr_* registration and the address computation, and is instantiated once.
- The FSM, read sequencing and flush logic stay in the top.

Test Plan:
- W=H=7, NUM_CH=1, rd_data = addr+1, engine model emitting 49 outputs -> 49 reads at addresses 0..48; exactly 25 zero-flush valid cycles; 49 writes at addresses 0..48; done 1 cycle after NEXT; busy falls with done.
- NUM_CH=4 -> 4 CLEAR pulses of 2 cycles each; channel 2 reads addresses 98..146 and writes addresses 98..146; exactly one done pulse.
- Engine model emits 50 outputs in channel 0 -> 49 writes, the 50th dropped, err_overflow=1, remaining channels complete normally.
- Engine model emits 40 outputs -> DRAIN lasts 256 cycles; err_timeout=1; next channel starts; done still asserted.
- CLR asserted during FLUSH of channel 1 -> next cycle all outputs 0, eng_clr=1; a subsequent start restarts at channel 0 address 0.
- start pulsed while busy and in the DONE cycle -> ignored; no extra reads; single done.

Source files
------------

// File: rtl/pool_sched_pkg.sv
// Shared state encoding, default geometry and sizing helpers for the
// pooling channel scheduler and its output collector.
package pool_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4,
    ST_NEXT  = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  localparam int DEF_IMG_W      = 7;
  localparam int DEF_IMG_H      = 7;
  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_DW         = 16;
  localparam int DEF_AW         = 16;
  localparam int DEF_TIMEOUT    = 256;
  localparam int DEF_CLR_CYCLES = 2;
  localparam int PIX_PER_CH     = DEF_IMG_W * DEF_IMG_H;

  // Bits needed to hold any value in 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Zero pixels needed to push the last window through the line buffer.
  function automatic int flush_len(input int img_w);
    return img_w * 3 + 4;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // True when every channel-packed address fits in an aw-bit space.
  function automatic bit addr_fits(input int num_ch, input int pix, input int aw);
    longint span;
    span = longint'(num_ch) * longint'(pix);
    return (aw >= 62) || (span <= (longint'(1) << aw));
  endfunction

endpackage

// File: rtl/pool_out_collector.sv
// Captures engine results into the output feature memory at channel-packed
// addresses; counts outputs per channel and flags any surplus output.
module pool_out_collector
  import pool_sched_pkg::*;
#(
  parameter int Datawidth  = DEF_DW,
  parameter int AW         = DEF_AW,
  parameter int OUT_PER_CH = PIX_PER_CH
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic                 err_clr,
  input  logic                 cnt_clr,
  input  logic                 capture_en,
  input  logic [AW-1:0]        ch_base,
  input  logic                 eng_valid_out,
  input  logic [Datawidth-1:0] eng_out,
  output logic                 out_full,
  output logic                 err_overflow,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [Datawidth-1:0] wr_data
);

  localparam int OUT_W = cnt_w(OUT_PER_CH);

  logic [OUT_W-1:0] out_cnt;

  assign out_full = (out_cnt == OUT_W'(OUT_PER_CH));

  always_ff @(posedge CLK) begin
    if (CLR) begin
      out_cnt      <= '0;
      err_overflow <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
    end else begin
      wr_en <= 1'b0;
      if (cnt_clr) begin
        out_cnt <= '0;
      end
      if (err_clr) begin
        err_overflow <= 1'b0;
      end
      if (capture_en && eng_valid_out) begin
        if (!out_full) begin
          wr_en   <= 1'b1;
          wr_addr <= ch_base + AW'(out_cnt);
          wr_data <= eng_out;
          out_cnt <= out_cnt + OUT_W'(1);
        end else begin
          err_overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pool_channel_scheduler.sv
// Runs the 7x7 window engine over a multi-channel feature map one channel
// at a time: clear, feed pixels, flush zeros, then drain results to memory.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_CLEAR | engine clear pulse, per-channel counters reset
// ST_FEED  | one input-memory read per cycle for the current channel
// ST_FLUSH | zero pixels pushed to drain the line buffer
// ST_DRAIN | waiting for the remaining outputs, bounded by the timeout
// ST_NEXT  | advance to the next channel or finish
// ST_DONE  | one-cycle done pulse
module pool_channel_scheduler
  import pool_sched_pkg::*;
#(
  parameter int IMG_Width  = DEF_IMG_W,
  parameter int IMG_Height = DEF_IMG_H,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int Datawidth  = DEF_DW,
  parameter int CLR_CYCLES = DEF_CLR_CYCLES,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int AW         = DEF_AW
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 err_timeout,
  output logic                 err_overflow,
  output logic                 rd_en,
  output logic [AW-1:0]        rd_addr,
  input  logic [Datawidth-1:0] rd_data,
  output logic                 eng_clr,
  output logic                 eng_valid_in,
  output logic [Datawidth-1:0] eng_in,
  input  logic                 eng_valid_out,
  input  logic [Datawidth-1:0] eng_out,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [Datawidth-1:0] wr_data
);

  localparam int OUT_PER_CH = IMG_Width * IMG_Height;
  localparam int FLUSH_LEN  = flush_len(IMG_Width);
  localparam int CH_W       = cnt_w(NUM_CH - 1);
  localparam int PIX_W      = cnt_w(OUT_PER_CH - 1);
  localparam int TMR_W      = cnt_w(max3(CLR_CYCLES, FLUSH_LEN, TIMEOUT) - 1);

  if (!addr_fits(NUM_CH, OUT_PER_CH, AW)) begin : g_addr_chk
    $error("NUM_CH*OUT_PER_CH exceeds the AW-bit address space");
  end

  state_t             state, state_next;
  logic [CH_W-1:0]    ch;
  logic [PIX_W-1:0]   pix_cnt;
  logic [TMR_W-1:0]   tmr;
  logic [AW-1:0]      ch_base;
  logic               feed_q, zero_q;
  logic               tmr_tc, last_pix, last_ch, out_full;
  logic               start_acc, drain_timeout, capture_en, cnt_clr, flush_issue;

  assign tmr_tc   = (tmr == '0);
  assign last_pix = (pix_cnt == PIX_W'(OUT_PER_CH - 1));
  assign last_ch  = (ch == CH_W'(NUM_CH - 1));
  assign ch_base  = AW'(ch) * AW'(OUT_PER_CH);
  assign rd_addr  = ch_base + AW'(pix_cnt);

  // Read data arrives one cycle after rd_en, aligned with the delayed strobe.
  assign eng_valid_in = feed_q | zero_q;
  assign eng_in       = feed_q ? rd_data : '0;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (start) state_next = ST_CLEAR;
      ST_CLEAR: if (tmr_tc) state_next = ST_FEED;
      ST_FEED:  if (last_pix) state_next = ST_FLUSH;
      ST_FLUSH: if (tmr_tc) state_next = ST_DRAIN;
      ST_DRAIN: if (out_full || tmr_tc) state_next = ST_NEXT;
      ST_NEXT:  state_next = last_ch ? ST_DONE : ST_CLEAR;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    rd_en         = 1'b0;
    eng_clr       = CLR;
    capture_en    = 1'b0;
    cnt_clr       = 1'b0;
    flush_issue   = 1'b0;
    start_acc     = 1'b0;
    drain_timeout = 1'b0;
    unique case (state)
      ST_IDLE:  start_acc = start;
      ST_CLEAR: begin
        busy    = 1'b1;
        eng_clr = 1'b1;
        cnt_clr = 1'b1;
      end
      ST_FEED: begin
        busy       = 1'b1;
        rd_en      = 1'b1;
        capture_en = 1'b1;
      end
      ST_FLUSH: begin
        busy        = 1'b1;
        flush_issue = 1'b1;
        capture_en  = 1'b1;
      end
      ST_DRAIN: begin
        busy          = 1'b1;
        capture_en    = 1'b1;
        drain_timeout = !out_full && tmr_tc;
      end
      ST_NEXT:  busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  busy = 1'b0;
    endcase
  end

  // One shared down-counter times CLEAR, FLUSH and DRAIN; loaded on entry.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      ch          <= '0;
      pix_cnt     <= '0;
      tmr         <= '0;
      feed_q      <= 1'b0;
      zero_q      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      feed_q <= rd_en;
      zero_q <= flush_issue;

      if (state_next != state) begin
        unique case (state_next)
          ST_CLEAR: tmr <= TMR_W'(CLR_CYCLES - 1);
          ST_FLUSH: tmr <= TMR_W'(FLUSH_LEN - 1);
          ST_DRAIN: tmr <= TMR_W'(TIMEOUT - 1);
          default:  tmr <= '0;
        endcase
      end else if (!tmr_tc) begin
        tmr <= tmr - TMR_W'(1);
      end

      if (start_acc) begin
        ch <= '0;
      end else if (state == ST_NEXT && !last_ch) begin
        ch <= ch + CH_W'(1);
      end

      if (cnt_clr) begin
        pix_cnt <= '0;
      end else if (rd_en) begin
        pix_cnt <= pix_cnt + PIX_W'(1);
      end

      if (start_acc) begin
        err_timeout <= 1'b0;
      end else if (drain_timeout) begin
        err_timeout <= 1'b1;
      end
    end
  end

  pool_out_collector #(
    .Datawidth (Datawidth),
    .AW        (AW),
    .OUT_PER_CH(OUT_PER_CH)
  ) u_out_collector (
    .CLK          (CLK),
    .CLR          (CLR),
    .err_clr      (start_acc),
    .cnt_clr      (cnt_clr),
    .capture_en   (capture_en),
    .ch_base      (ch_base),
    .eng_valid_out(eng_valid_out),
    .eng_out      (eng_out),
    .out_full     (out_full),
    .err_overflow (err_overflow),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data)
  );

endmodule
